// File: rtl/idct8_row_if.sv
// idct8_row_if: coefficient-in and sample-out streams of idct8_row.
// Both directions are valid/ready; out_last marks sample x[7].
interface idct8_row_if #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 12
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_last;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );
endinterface

// File: rtl/idct8_row.sv
// idct8_row: 8-point row IDCT using one serial MAC and a cosine table.
// Define IDCT8_SAT_EN to saturate samples; otherwise they wrap.
module idct8_row #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 12,
   parameter int SHIFT = 12
) (
   input logic        clock,
   input logic        reset_n,
   idct8_row_if.slave bus
);
   localparam int ACC_W = IN_W + 13 + 3;
   localparam logic signed [ACC_W-1:0] HALF =
      ACC_W'(2 ** (SHIFT - 1));

   typedef enum logic [1:0] {
      LOAD,
      MAC,
      EMIT
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [2:0]              cnt;
   logic [2:0]              k;
   logic [2:0]              n;
   logic signed [IN_W-1:0]  row_q [8];
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nx;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] rnd;
   logic signed [OUT_W-1:0] samp;
   logic signed [OUT_W-1:0] dout_q;
   logic                    last_q;

   // floor(2048*c_k*cos(m*pi/16)) with m = (2n+1)k folded into 0..16
   function automatic logic signed [12:0] coef(
      input logic [2:0] kk,
      input logic [2:0] nn
   );
      logic [4:0]         a;
      logic [4:0]         b;
      logic [4:0]         m;
      logic signed [12:0] c;
      a = {1'b0, nn, 1'b1};
      b = {2'b00, kk};
      m = a * b;
      if (m > 5'd16) m = 5'd0 - m;
      case (m)
         5'd0:    c = 13'sd2048;
         5'd1:    c = 13'sd2008;
         5'd2:    c = 13'sd1892;
         5'd3:    c = 13'sd1702;
         5'd4:    c = 13'sd1448;
         5'd5:    c = 13'sd1137;
         5'd6:    c = 13'sd783;
         5'd7:    c = 13'sd399;
         5'd9:    c = -13'sd400;
         5'd10:   c = -13'sd784;
         5'd11:   c = -13'sd1138;
         5'd12:   c = -13'sd1449;
         5'd13:   c = -13'sd1703;
         5'd14:   c = -13'sd1893;
         5'd15:   c = -13'sd2009;
         5'd16:   c = -13'sd2048;
         default: c = 13'sd0;
      endcase
      if (kk == 3'd0) c = 13'sd1448;
      return c;
   endfunction

   // MAC step and rounding offset for the current k, n
   always_comb begin
      prod   = ACC_W'(coef(k, n)) * ACC_W'(row_q[k]);
      acc_nx = acc + prod;
      rnd    = acc_nx + HALF;
   end

`ifdef IDCT8_SAT_EN
   localparam logic signed [ACC_W-1:0] OMAX =
      ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] OMIN =
      -ACC_W'(2 ** (OUT_W - 1));

   logic signed [ACC_W-1:0] r;

   // round then saturate to the output range
   always_comb begin
      r    = rnd >>> SHIFT;
      samp = r[OUT_W-1:0];
      if (r > OMAX) samp = OMAX[OUT_W-1:0];
      else if (r < OMIN) samp = OMIN[OUT_W-1:0];
   end
`else
   // round then keep the low bits (two's-complement wrap)
   always_comb begin
      samp = OUT_W'(rnd >>> SHIFT);
   end
`endif

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= LOAD;
      else          state <= state_nx;
   end

   // next-state: 8 loads, then 8 MAC cycles + 1 emit per sample
   always_comb begin
      state_nx = state;
      unique case (state)
         LOAD:
            if (bus.in_valid && cnt == 3'd7)
               state_nx = MAC;
         MAC:
            if (k == 3'd7)
               state_nx = EMIT;
         EMIT:
            if (bus.out_ready)
               state_nx = (n == 3'd7) ? LOAD : MAC;
         default: state_nx = LOAD;
      endcase
   end

   // row buffer, counters, accumulator and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         k      <= '0;
         n      <= '0;
         acc    <= '0;
         dout_q <= '0;
         last_q <= 1'b0;
         for (int i = 0; i < 8; i++) row_q[i] <= '0;
      end else begin
         unique case (state)
            LOAD:
               if (bus.in_valid) begin
                  row_q[cnt] <= $signed(bus.in_data);
                  cnt        <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     n   <= '0;
                     k   <= '0;
                     acc <= '0;
                  end
               end
            MAC: begin
               acc <= acc_nx;
               k   <= k + 3'd1;
               if (k == 3'd7) begin
                  dout_q <= samp;
                  last_q <= (n == 3'd7);
               end
            end
            EMIT:
               if (bus.out_ready) begin
                  if (n != 3'd7) n <= n + 3'd1;
                  k   <= '0;
                  acc <= '0;
               end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == LOAD);
   assign bus.out_valid = (state == EMIT);
   assign bus.out_data  = dout_q;
   assign bus.out_last  = last_q;
endmodule

// File: tb/tb_idct8_row.sv
// tb_idct8_row: randomized bench for idct8_row against a real-valued
// IDCT reference built from the cosine formula.
module tb_idct8_row;
   localparam real PI = 3.141592653589793;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   ctab [8][8];

   idct8_row_if #(.IN_W(12), .OUT_W(12)) bus ();

   idct8_row #(
      .IN_W (12),
      .OUT_W(12),
      .SHIFT(12)
   ) dut (
      .clock  (clk),
      .reset_n(rst_n),
      .bus    (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void build_table();
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            real ck;
            real v;
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            v  = 2048.0 * ck * $cos((2 * n + 1) * k * PI / 16.0);
            ctab[k][n] = int'($floor(v));
         end
      end
   endfunction

   function automatic int model_x(input int x[8], input int n);
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < 8; k++)
         acc += longint'(ctab[k][n]) * longint'(x[k]);
      r = longint'($floor(real'(acc) / 4096.0 + 0.5));
`ifdef IDCT8_SAT_EN
      if (r > 2047) r = 2047;
      if (r < -2048) r = -2048;
`else
      r = ((r % 4096) + 4096) % 4096;
      if (r >= 2048) r -= 4096;
`endif
      return int'(r);
   endfunction

   task automatic send_row(input int x[8], output bit to);
      to = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int w;
         w = 0;
         bus.in_valid = 1'b1;
         bus.in_data  = 12'(x[i]);
         @(negedge clk);
         while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (!bus.in_ready) begin
            to = 1'b1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic recv_row(input bit rand_rdy, input bit noise,
                           output int d[8], output bit l[8],
                           output int first_cyc, output bit to);
      int i;
      int w;
      i = 0;
      w = 0;
      first_cyc = -1;
      for (int j = 0; j < 8; j++) begin
         d[j] = 0;
         l[j] = 1'b0;
      end
      while (i < 8 && w < 2000) begin
         bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.in_data   = 12'($urandom);
         @(negedge clk);
         if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            d[i] = int'($signed(bus.out_data));
            l[i] = bus.out_last;
            if (i == 7) bus.in_valid = 1'b0;
            i++;
         end
         @(posedge clk);
         #1;
         w++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      to = (i < 8);
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      else passed++;
      total++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      else passed++;
      total++;
      if (bus.out_last !== 1'b0)
         $display("FAIL reset_out_last got=%b exp=0", bus.out_last);
      else passed++;
      total++;
      if (bus.out_data !== 12'd0)
         $display("FAIL reset_out_data got=%0d exp=0", bus.out_data);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_dc();
      int x[8];
      int d[8];
      bit l[8];
      int fc;
      bit to;
      x = '{1024, 0, 0, 0, 0, 0, 0, 0};
      send_row(x, to);
      total++;
      if (to) begin
         $display("FAIL dc_send timeout got=stall exp=accept");
         return;
      end
      passed++;
      recv_row(1'b0, 1'b0, d, l, fc, to);
      total++;
      if (to) begin
         $display("FAIL dc_recv timeout got=stall exp=8 samples");
         return;
      end
      passed++;
      total++;
      if (fc - acc_cyc !== 8)
         $display("FAIL dc_latency got=%0d exp=8", fc - acc_cyc);
      else passed++;
      total++;
      if (d[0] !== 362)
         $display("FAIL dc_x0_const got=%0d exp=362", d[0]);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== model_x(x, i))
            $display("FAIL dc_x%0d got=%0d exp=%0d", i, d[i], model_x(x, i));
         else passed++;
         total++;
         if (l[i] !== (i == 7))
            $display("FAIL dc_last%0d got=%b exp=%b", i, l[i], i == 7);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int z[8];
      int x[8];
      int d[8];
      bit l[8];
      int fc;
      bit to;
      for (int i = 0; i < 8; i++) begin
         z[i] = 0;
         x[i] = int'($urandom_range(0, 4095)) - 2048;
      end
      send_row(z, to);
      recv_row(1'b0, 1'b0, d, l, fc, to);
      total++;
      if (to) begin
         $display("FAIL zero_recv timeout got=stall exp=8 samples");
         return;
      end
      passed++;
      total++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== 0)
            $display("FAIL zero_x%0d got=%0d exp=0", i, d[i]);
         else passed++;
      end
      send_row(x, to);
      recv_row(1'b0, 1'b0, d, l, fc, to);
      total++;
      if (to) begin
         $display("FAIL b2b_recv timeout got=stall exp=8 samples");
         return;
      end
      passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== model_x(x, i))
            $display("FAIL b2b_x%0d got=%0d exp=%0d", i, d[i], model_x(x, i));
         else passed++;
      end
   endtask

   task automatic test_saturation();
      int x[8];
      int d[8];
      bit l[8];
      int fc;
      bit to;
      int exp0;
      for (int i = 0; i < 8; i++) x[i] = 2047;
`ifdef IDCT8_SAT_EN
      exp0 = 2047;
`else
      exp0 = 1310;
`endif
      send_row(x, to);
      recv_row(1'b0, 1'b0, d, l, fc, to);
      total++;
      if (to) begin
         $display("FAIL sat_recv timeout got=stall exp=8 samples");
         return;
      end
      passed++;
      total++;
      if (d[0] !== exp0)
         $display("FAIL sat_x0_const got=%0d exp=%0d", d[0], exp0);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== model_x(x, i))
            $display("FAIL sat_x%0d got=%0d exp=%0d", i, d[i], model_x(x, i));
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int         x[8];
      int         d[8];
      bit         l[8];
      bit         to;
      bit         stable;
      logic [11:0] hd;
      x = '{0, 2047, 0, 0, 0, 0, 0, 0};
      stable = 1'b1;
      send_row(x, to);
      for (int i = 0; i < 8; i++) begin
         int w;
         w = 0;
         bus.out_ready = (i != 3);
         @(negedge clk);
         while (!bus.out_valid && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (!bus.out_valid) begin
            total++;
            $display("FAIL bp_wait%0d timeout got=stall exp=valid", i);
            bus.out_ready = 1'b1;
            return;
         end
         hd   = bus.out_data;
         d[i] = int'($signed(bus.out_data));
         l[i] = bus.out_last;
         if (i == 3) begin
            repeat (20) begin
               @(negedge clk);
               if (bus.out_valid !== 1'b1 || bus.out_data !== hd ||
                   bus.out_last !== l[i] || bus.in_ready !== 1'b0)
                  stable = 1'b0;
            end
            bus.out_ready = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (stable !== 1'b1)
         $display("FAIL bp_hold got=changed exp=stable");
      else passed++;
      total++;
      if (d[0] !== 1004)
         $display("FAIL bp_x0_const got=%0d exp=1004", d[0]);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== model_x(x, i) || l[i] !== (i == 7))
            $display("FAIL bp_x%0d got=%0d/%b exp=%0d/%b", i, d[i], l[i],
                     model_x(x, i), i == 7);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int x[8];
      int d[8];
      bit l[8];
      int fc;
      bit to;
      bit extra;
      x = '{1024, 0, 0, 0, 0, 0, 0, 0};
      send_row(x, to);
      for (int i = 0; i < 4; i++) begin
         int w;
         w = 0;
         @(negedge clk);
         while (!bus.out_valid && w < 200) begin
            @(negedge clk);
            w++;
         end
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL mid_reset got=v%b r%b exp=v0 r1",
                  bus.out_valid, bus.in_ready);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_row(x, to);
      recv_row(1'b0, 1'b0, d, l, fc, to);
      total++;
      if (to) begin
         $display("FAIL mid_recv timeout got=stall exp=8 samples");
         return;
      end
      passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (d[i] !== 362 || l[i] !== (i == 7))
            $display("FAIL mid_x%0d got=%0d/%b exp=362/%b", i, d[i], l[i],
                     i == 7);
         else passed++;
      end
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) extra = 1'b1;
      end
      total++;
      if (extra !== 1'b0)
         $display("FAIL mid_stale got=extra sample exp=none");
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random(input int rows);
      int x[8];
      int d[8];
      bit l[8];
      int fc;
      bit to;
      int bad;
      for (int r = 0; r < rows; r++) begin
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 7))
               0:       x[i] = 2047;
               1:       x[i] = -2048;
               default: x[i] = int'($urandom_range(0, 4095)) - 2048;
            endcase
         end
         send_row(x, to);
         if (to) begin
            total++;
            $display("FAIL rnd_send row%0d got=stall exp=accept", r);
            return;
         end
         recv_row(1'b1, 1'b1, d, l, fc, to);
         if (to) begin
            total++;
            $display("FAIL rnd_recv row%0d got=stall exp=8 samples", r);
            return;
         end
         bad = 0;
         for (int i = 0; i < 8; i++) begin
            total++;
            if (d[i] !== model_x(x, i) || l[i] !== (i == 7)) begin
               if (bad < 4)
                  $display("FAIL rnd row%0d x%0d got=%0d/%b exp=%0d/%b",
                           r, i, d[i], l[i], model_x(x, i), i == 7);
               bad++;
            end else passed++;
         end
      end
   endtask

   initial begin
      build_table();
      test_reset();
      test_dc();
      test_back_to_back();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_random(1000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
